// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional feature macro: DMEM_STORE_BUFFER_EN (one-entry posted store buffer).
package dmem_responder_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Store size codes (func3[1:0])
  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  // Load size codes (func3)
  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  // Byte enables for a store; unknown sizes behave as a full word
  function automatic logic [NUM_LANES-1:0] st_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      ST_SB:   return 4'(4'b0001 << lane);
      ST_SH:   return 4'(4'b0011 << {lane[1], 1'b0});
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so any lane select picks the right bytes
  function automatic logic [DATA_W-1:0] st_wdata(input logic [1:0] size, input logic [DATA_W-1:0] data);
    case (size)
      ST_SB:   return {4{data[7:0]}};
      ST_SH:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic st_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      ST_SB:   return 1'b0;
      ST_SH:   return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  function automatic logic ld_misaligned(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      FNC_LH, FNC_LHU: return lane[0];
      FNC_LW:          return lane != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_load_align.sv
// Selects the addressed byte/half of a raw memory word and sign/zero-extends it.
module dmem_responder_load_align
  import dmem_responder_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        lane_i,
  input  logic [2:0]        ld_size_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction and extension; unknown sizes pass the raw word through
  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = word_i[{lane_i[1], 4'b0000} +: 16];
    rdata_o  = word_i;
    case (ld_size_i)
      FNC_LB:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      FNC_LBU: rdata_o = {24'b0, byte_sel};
      FNC_LH:  rdata_o = {{16{half_sel[15]}}, half_sel};
      FNC_LHU: rdata_o = {16'b0, half_sel};
      default: rdata_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts pipeline load/store commands, runs one
// req/resp transaction at a time to backing memory, returns formatted load data.
// Optional feature macro: DMEM_STORE_BUFFER_EN (stores post and drain in background).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dc_re,
  input  logic                 dc_we,
  input  logic [ADDR_W-1:0]    dc_addr,
  input  logic [DATA_W-1:0]    dc_wdata,
  input  logic [1:0]           st_size,
  input  logic [2:0]           ld_size,
  output logic [DATA_W-1:0]    dc_rdata,
  output logic                 dc_rvalid,
  output logic                 dc_stall,
  output logic                 dc_misalign,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_rw,
  output logic [ADDR_W-1:0]    mem_req_addr,
  output logic [DATA_W-1:0]    mem_req_wdata,
  output logic [NUM_LANES-1:0] mem_req_wmask,
  input  logic                 mem_resp_valid,
  input  logic [DATA_W-1:0]    mem_resp_rdata
);

`ifdef DMEM_STORE_BUFFER_EN
  localparam logic SB_EN = 1'b1;
`else
  localparam logic SB_EN = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic                   req_valid_q, req_valid_d;
  logic                   req_rw_q, req_rw_d;
  logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
  logic [DATA_W-1:0]      req_wdata_q, req_wdata_d;
  logic [NUM_LANES-1:0]   req_wmask_q, req_wmask_d;
  logic [1:0]             lane_q, lane_d;
  logic [2:0]             ld_size_q, ld_size_d;
  logic                   posted_q, posted_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   misalign_q, misalign_d;

  logic                   cmd_valid;
  logic                   is_store;
  logic [1:0]             cmd_lane;
  logic                   cmd_mis;
  logic                   stall_c;
  logic [DATA_W-1:0]      align_data;

  assign cmd_valid = dc_re | dc_we;
  assign is_store  = dc_we;
  assign cmd_lane  = dc_addr[1:0];
  assign cmd_mis   = is_store ? st_misaligned(st_size, cmd_lane)
                              : ld_misaligned(ld_size, cmd_lane);

  dmem_responder_load_align u_align (
    .word_i    (mem_resp_rdata),
    .lane_i    (lane_q),
    .ld_size_i (ld_size_q),
    .rdata_o   (align_data)
  );

  // Next-state and next-output computation for the transaction sequencer
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_rw_d    = req_rw_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    lane_d      = lane_q;
    ld_size_d   = ld_size_q;
    posted_d    = posted_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    misalign_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_mis) begin
            misalign_d = 1'b1;
            if (!is_store) rdata_d = '0;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_rw_d    = is_store;
            req_addr_d  = {dc_addr[ADDR_W-1:2], 2'b00};
            req_wdata_d = is_store ? st_wdata(st_size, dc_wdata) : '0;
            req_wmask_d = is_store ? st_mask(st_size, cmd_lane) : '0;
            lane_d      = cmd_lane;
            ld_size_d   = ld_size;
            posted_d    = is_store & SB_EN;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          if (posted_q) begin
            state_d  = S_IDLE;
            posted_d = 1'b0;
          end else begin
            state_d = S_DONE;
            if (!req_rw_q) begin
              rvalid_d = 1'b1;
              rdata_d  = align_data;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pipeline hold: blocking transactions stall until DONE; a draining posted
  // store only stalls a new command that arrives behind it
  always_comb begin
    stall_c = 1'b0;
    case (state_q)
      S_IDLE:         stall_c = cmd_valid & ~cmd_mis & ~(is_store & SB_EN);
      S_REQ, S_WAIT:  stall_c = posted_q ? cmd_valid : 1'b1;
      default:        stall_c = 1'b0;
    endcase
  end

  assign dc_stall = reset & stall_c;

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      lane_q      <= 2'b00;
      ld_size_q   <= 3'b000;
      posted_q    <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_rw_q    <= req_rw_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      lane_q      <= lane_d;
      ld_size_q   <= ld_size_d;
      posted_q    <= posted_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      misalign_q  <= misalign_d;
    end
  end

  assign dc_rdata      = rdata_q;
  assign dc_rvalid     = rvalid_q;
  assign dc_misalign   = misalign_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_rw    = req_rw_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-level reference memory model,
// a backing-memory responder, and a per-cycle output checker.
module tb_dmem_responder;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101, LRAW = 3'b011;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;
`ifdef DMEM_STORE_BUFFER_EN
  localparam int ST_STALL = 0, T6_ST2 = 2, T6_LD = 5;
`else
  localparam int ST_STALL = 3, T6_ST2 = 3, T6_LD = 3;
`endif

  logic        clk, reset;
  logic        dc_re, dc_we;
  logic [31:0] dc_addr, dc_wdata;
  logic [1:0]  st_size;
  logic [2:0]  ld_size;
  logic [31:0] dc_rdata;
  logic        dc_rvalid, dc_stall, dc_misalign;
  logic        mem_req_valid, mem_req_ready, mem_req_rw;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  dmem_responder #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .dc_re(dc_re), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .st_size(st_size), .ld_size(ld_size), .dc_rdata(dc_rdata),
    .dc_rvalid(dc_rvalid), .dc_stall(dc_stall), .dc_misalign(dc_misalign),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  int total = 0, bad = 0;
  logic [7:0]  ref_mem [int];
  logic [31:0] bmem    [int];
  req_t        exp_req [$];
  logic [31:0] exp_load[$];
  bit          exp_mis [$];

  logic        hold = 1'b0, stray = 1'b0;
  int          ready_lat = 0, resp_lat = 1;
  int          req_count = 0, rv_count = 0, mis_count = 0;
  logic        last_rw;
  logic [31:0] last_addr, last_wdata, last_rdata;
  logic [3:0]  last_wmask;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", nm, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] c);
    return (c == 2'b00) ? 1 : ((c == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit ld_known(input logic [2:0] c);
    return c inside {LB, LH, LW, LBU, LHU};
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return 8'h00;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] c);
    logic [31:0] v;
    int n;
    v = '0;
    if (!ld_known(c)) begin
      for (int k = 0; k < 4; k++) v[8*k +: 8] = ref_byte((a & ~32'd3) + 32'(k));
      return v;
    end
    n = nbytes(c[1:0]);
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_byte(a + 32'(k));
    if (!c[2] && v[8*n-1]) for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    bmem[int'(a >> 2)] = w;
    for (int k = 0; k < 4; k++) ref_mem[int'(a) + k] = w[8*k +: 8];
  endtask

  // Present one command and hold it until the pipeline is released
  task automatic do_cmd(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] ls, input logic [1:0] ss, input int exp_stall, input string nm);
    int n, off, stalls;
    req_t r;
    n = we ? nbytes(ss) : (ld_known(ls) ? nbytes(ls[1:0]) : 1);
    if ((int'(a) % n) != 0) begin
      exp_mis.push_back(!we);
    end else begin
      off     = int'(a) % 4;
      r.rw    = we;
      r.addr  = a & ~32'd3;
      r.wdata = '0;
      r.wmask = '0;
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          r.wmask[i]       = (i >= off) && (i < off + n);
          r.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
      end else begin
        exp_load.push_back(model_load(a, ls));
      end
      exp_req.push_back(r);
    end
    @(posedge clk); #1;
    dc_re = re; dc_we = we; dc_addr = a; dc_wdata = wd; ld_size = ls; st_size = ss;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!dc_stall) break;
      stalls++;
      if (stalls > 60) break;
      @(posedge clk); #1;
    end
    check({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    dc_re = 1'b0; dc_we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- backing memory ----------------
  initial begin : memory
    int resp_cnt, wait_cnt, idx;
    logic [31:0] word, rd_word;
    req_t e;
    resp_cnt = 0; wait_cnt = 0; rd_word = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!reset) begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; resp_cnt = 0; wait_cnt = 0;
      end else begin
        mem_resp_valid = 1'b0;
        if (mem_req_ready) begin
          req_count++;
          last_rw = mem_req_rw; last_addr = mem_req_addr;
          last_wdata = mem_req_wdata; last_wmask = mem_req_wmask;
          if (exp_req.size() > 0) begin
            e = exp_req.pop_front();
            check("req_rw",    32'(mem_req_rw),    32'(e.rw));
            check("req_addr",  mem_req_addr,       e.addr);
            check("req_wmask", 32'(mem_req_wmask), 32'(e.wmask));
            check("req_wdata", mem_req_wdata,      e.wdata);
          end
          idx  = int'(mem_req_addr >> 2);
          word = bmem.exists(idx) ? bmem[idx] : 32'h0;
          if (mem_req_rw) begin
            for (int i = 0; i < 4; i++) if (mem_req_wmask[i]) word[8*i +: 8] = mem_req_wdata[8*i +: 8];
            bmem[idx] = word;
          end
          rd_word  = word;
          resp_cnt = resp_lat;
        end
        mem_req_ready = 1'b0;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rd_word;
          end
        end else if (stray) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = 32'hBAD0_BAD0;
          stray = 1'b0;
        end
        if (mem_req_valid && !hold) begin
          if (wait_cnt >= ready_lat) begin
            mem_req_ready = 1'b1;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // ---------------- per-cycle output checker ----------------
  initial begin : compare
    logic        prev_valid, prev_rw;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_wmask;
    bit          ld;
    prev_valid = 1'b0; prev_rw = 1'b0; prev_addr = '0; prev_wdata = '0; prev_wmask = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("spurious_rvalid",   32'(dc_rvalid && exp_load.size() == 0), 32'h0);
        check("spurious_misalign", 32'(dc_misalign && exp_mis.size() == 0), 32'h0);
        check("spurious_req",      32'(mem_req_valid && exp_req.size() == 0), 32'h0);
        if (dc_rvalid && exp_load.size() > 0) begin
          rv_count++;
          last_rdata = dc_rdata;
          check("load_data", dc_rdata, exp_load.pop_front());
        end
        if (dc_misalign && exp_mis.size() > 0) begin
          mis_count++;
          ld = exp_mis.pop_front();
          if (ld) check("misalign_load_data", dc_rdata, 32'h0);
        end
        if (mem_req_valid && prev_valid) begin
          check("req_stable_addr",  mem_req_addr, prev_addr);
          check("req_stable_wdata", mem_req_wdata, prev_wdata);
          check("req_stable_ctl",   {27'b0, mem_req_rw, mem_req_wmask}, {27'b0, prev_rw, prev_wmask});
        end
      end
      prev_valid = mem_req_valid && reset;
      prev_rw = mem_req_rw; prev_addr = mem_req_addr;
      prev_wdata = mem_req_wdata; prev_wmask = mem_req_wmask;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int n0;
    reset = 1'b0; dc_re = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0; ld_size = LW; st_size = SW;
    preload(32'h100, 32'hDEAD_BEEF);
    preload(32'h200, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1; dc_re = 1'b1; dc_addr = 32'h100;
    @(negedge clk);
    check("rst_stall_gated", 32'(dc_stall), 32'h0);
    @(posedge clk); #1;
    dc_re = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst_outputs", {dc_rdata}, 32'h0);
    check("rst_ctl", {26'b0, dc_rvalid, dc_stall, dc_misalign, mem_req_valid, mem_req_rw, 1'b0}, 32'h0);
    check("rst_req", mem_req_addr | mem_req_wdata | {28'b0, mem_req_wmask}, 32'h0);

    // 1: word load, fastest memory
    do_cmd(1'b1, 1'b0, 32'h100, 32'h0, LW, SW, 3, "t1_lw");
    idle(2);
    check("t1_lw_literal", last_rdata, 32'hDEAD_BEEF);

    // 2: byte/half extraction on 0x80FF0000
    do_cmd(1'b0, 1'b1, 32'h100, 32'h80FF_0000, LW, SW, ST_STALL, "t2_sw");
    idle(4);
    do_cmd(1'b1, 1'b0, 32'h103, 32'h0, LB, SW, 3, "t2_lb");
    idle(2);
    check("t2_lb_literal", last_rdata, 32'hFFFF_FF80);
    do_cmd(1'b1, 1'b0, 32'h103, 32'h0, LBU, SW, 3, "t2_lbu");
    idle(2);
    check("t2_lbu_literal", last_rdata, 32'h0000_0080);
    do_cmd(1'b1, 1'b0, 32'h102, 32'h0, LH, SW, 3, "t2_lh");
    idle(2);
    check("t2_lh_literal", last_rdata, 32'hFFFF_80FF);
    do_cmd(1'b1, 1'b0, 32'h102, 32'h0, LHU, SW, 3, "t2_lhu");
    do_cmd(1'b1, 1'b0, 32'h101, 32'h0, LB, SW, 3, "t2_lb1");

    // 3: sub-word stores, masks and replication
    do_cmd(1'b0, 1'b1, 32'h201, 32'h1234_5678, LW, SB, ST_STALL, "t3_sb");
    idle(4);
    check("t3_sb_wmask", 32'(last_wmask), 32'h2);
    check("t3_sb_wdata", last_wdata, 32'h7878_7878);
    check("t3_sb_addr",  last_addr, 32'h200);
    check("t3_sb_rw",    32'(last_rw), 32'h1);
    do_cmd(1'b0, 1'b1, 32'h202, 32'h0000_ABCD, LW, SH, ST_STALL, "t3_sh");
    idle(4);
    check("t3_sh_wmask", 32'(last_wmask), 32'hC);
    check("t3_sh_wdata", last_wdata, 32'hABCD_ABCD);
    do_cmd(1'b1, 1'b0, 32'h200, 32'h0, LW, SW, 3, "t3_lw");
    idle(2);
    check("t3_lw_literal", last_rdata, 32'hABCD_7800);

    // 4: misaligned accesses are dropped without stalling
    n0 = req_count;
    do_cmd(1'b0, 1'b1, 32'h102, 32'hFFFF_FFFF, LW, SW, 0, "t4_sw_mis");
    do_cmd(1'b1, 1'b0, 32'h101, 32'h0, LH, SW, 0, "t4_lh_mis");
    do_cmd(1'b1, 1'b0, 32'h203, 32'h0, LW, SW, 0, "t4_lw_mis");
    idle(3);
    check("t4_no_requests", 32'(req_count - n0), 32'h0);
    check("t4_misalign_pulses", 32'(mis_count), 32'h3);
    // re+we together acts as a store; unknown load size returns the raw word
    do_cmd(1'b1, 1'b1, 32'h300, 32'h0000_005A, LW, SB, ST_STALL, "t4_rewe");
    idle(4);
    check("t4_rewe_rw", 32'(last_rw), 32'h1);
    do_cmd(1'b1, 1'b0, 32'h302, 32'h0, LRAW, SW, 3, "t4_raw");
    idle(2);
    check("t4_raw_literal", last_rdata, 32'h0000_005A);

    // 5: memory never ready, then reset mid-transaction
    hold = 1'b1;
    exp_req.push_back('{1'b0, 32'h100, 32'h0, 4'h0});
    exp_load.push_back(model_load(32'h100, LW));
    @(posedge clk); #1;
    dc_re = 1'b1; dc_we = 1'b0; dc_addr = 32'h100; ld_size = LW;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t5_stall_held", 32'(dc_stall), 32'h1);
      if (c > 0) check("t5_req_held", 32'(mem_req_valid), 32'h1);
    end
    @(posedge clk); #1;
    reset = 1'b0; dc_re = 1'b0;
    exp_req.delete(); exp_load.delete(); exp_mis.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_data", dc_rdata, 32'h0000_005A & 32'h0);
    check("t5_rst_ctl", {27'b0, dc_rvalid, dc_stall, dc_misalign, mem_req_valid, mem_req_rw}, 32'h0);
    check("t5_rst_req", mem_req_addr | mem_req_wdata | {28'b0, mem_req_wmask}, 32'h0);
    hold = 1'b0;
    n0 = rv_count;
    stray = 1'b1;
    idle(5);
    check("t5_stray_ignored", 32'(rv_count - n0), 32'h0);
    do_cmd(1'b1, 1'b0, 32'h100, 32'h0, LW, SW, 3, "t5_recover");
    idle(2);
    check("t5_recover_literal", last_rdata, 32'h80FF_0000);

    // 6: back-to-back SW, SW, LW
    do_cmd(1'b0, 1'b1, 32'h400, 32'h1111_1111, LW, SW, ST_STALL, "t6_sw1");
    do_cmd(1'b0, 1'b1, 32'h400, 32'h2222_2222, LW, SW, T6_ST2, "t6_sw2");
    do_cmd(1'b1, 1'b0, 32'h400, 32'h0, LW, SW, T6_LD, "t6_lw");
    idle(5);
    check("t6_lw_literal", last_rdata, 32'h2222_2222);

    check("end_loads_pending",   32'(exp_load.size()), 32'h0);
    check("end_reqs_pending",    32'(exp_req.size()),  32'h0);
    check("end_misalign_pending", 32'(exp_mis.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
